// File: rtl/handshake_const_check.sv
// Consumer-side checker for a constant-generator handshake channel.
// Each accepted input token is compared against CONST_VALUE; the 1-bit match
// result is queued in a 2-entry output buffer and mismatches are counted with
// saturation.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   ins, ins_valid    input token and its valid
//   ins_ready         buffer has room (fewer than 2 entries)
//   outs, outs_valid  match bit of the head token and its valid
//   outs_ready        downstream ready
//   mismatch_count    saturating count of accepted tokens that did not match
//   mismatch_sat      mismatch_count is all-ones
module handshake_const_check #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [31:0] CONST_VALUE = 32'hFFFF_FFFD,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic                  mismatch_sat
);

  localparam logic [DATA_WIDTH-1:0] CONST_W = DATA_WIDTH'(CONST_VALUE);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e                 state_q, state_d;
  logic                 head_q, head_d;
  logic                 tail_q, tail_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic accept_c;
  logic release_c;
  logic match_c;

  // Handshake qualifiers; both come from registered state only
  assign accept_c  = ins_valid && (state_q != FULL);
  assign release_c = outs_ready && (state_q != EMPTY);
  assign match_c   = (ins == CONST_W);

  // State and payload registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, buffer slot and counter logic
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;

    case (state_q)
      EMPTY: begin
        if (accept_c) begin
          state_d = ONE;
          head_d  = match_c;
        end
      end
      ONE: begin
        if (accept_c && !release_c) begin
          state_d = FULL;
          tail_d  = match_c;
        end else if (release_c && !accept_c) begin
          state_d = EMPTY;
        end else if (accept_c && release_c) begin
          // Head leaves and the new token takes its place
          head_d = match_c;
        end
      end
      FULL: begin
        if (release_c) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (accept_c && !match_c && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Outputs decoded from registers only
  assign ins_ready      = (state_q != FULL);
  assign outs_valid     = (state_q != EMPTY);
  assign outs           = head_q;
  assign mismatch_count = cnt_q;
  assign mismatch_sat   = &cnt_q;

endmodule

// File: tb/tb_handshake_const_check.sv
module tb_handshake_const_check;

  localparam logic [31:0] NEG3 = 32'hFFFF_FFFD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ins = '0;
  logic        ins_valid = 1'b0;
  logic        outs_ready = 1'b0;

  logic        ins_ready, outs, outs_valid, mismatch_sat;
  logic [15:0] mismatch_count;
  logic        ins_ready4, outs4, outs_valid4, mismatch_sat4;
  logic [3:0]  mismatch_count4;

  handshake_const_check dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready),
    .mismatch_count(mismatch_count), .mismatch_sat(mismatch_sat)
  );

  handshake_const_check #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready4),
    .outs(outs4), .outs_valid(outs_valid4), .outs_ready(outs_ready),
    .mismatch_count(mismatch_count4), .mismatch_sat(mismatch_sat4)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queue of pending match bits and an unbounded mismatch tally
  bit q[$];
  int mm_total = 0;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        e_ov;
    logic        e_outs;
    logic        e_ir;
    int          e_cnt;
  } vec_t;

  vec_t stream_tbl[7];
  vec_t bp_tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_at(input int n, input int lim);
    return (n > lim) ? lim : n;
  endfunction

  task automatic check_model();
    chk("ins_ready", 32'(ins_ready), 32'(q.size() < 2));
    chk("outs_valid", 32'(outs_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk("outs", 32'(outs), 32'(q[0]));
    chk("count", 32'(mismatch_count), 32'(sat_at(mm_total, 65535)));
    chk("sat", 32'(mismatch_sat), 32'(mm_total >= 65535));
    chk("ins_ready4", 32'(ins_ready4), 32'(q.size() < 2));
    chk("count4", 32'(mismatch_count4), 32'(sat_at(mm_total, 15)));
    chk("sat4", 32'(mismatch_sat4), 32'(mm_total >= 15));
  endtask

  // Inputs already driven after a falling edge; check, then advance one clock
  task automatic step();
    bit acc, rel, m;
    #1;
    check_model();
    acc = ins_valid && (q.size() < 2);
    rel = outs_ready && (q.size() > 0);
    m   = (ins == NEG3);
    @(posedge clk);
    if (rel) void'(q.pop_front());
    if (acc) begin
      q.push_back(m);
      if (!m) mm_total++;
    end
    @(negedge clk);
  endtask

  task automatic cycle(input logic v, input logic [31:0] d, input logic r);
    ins_valid  = v;
    ins        = d;
    outs_ready = r;
    step();
  endtask

  task automatic apply_vec(input vec_t t, input string tag);
    ins_valid  = t.v;
    ins        = t.d;
    outs_ready = t.r;
    #1;
    chk({tag, ".outs_valid"}, 32'(outs_valid), 32'(t.e_ov));
    if (t.e_ov) chk({tag, ".outs"}, 32'(outs), 32'(t.e_outs));
    chk({tag, ".ins_ready"}, 32'(ins_ready), 32'(t.e_ir));
    chk({tag, ".count"}, 32'(mismatch_count), 32'(t.e_cnt));
    step();
  endtask

  task automatic do_reset();
    ins_valid  = 1'b0;
    outs_ready = 1'b0;
    rst = 1'b0;
    q.delete();
    mm_total = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.outs_valid", 32'(outs_valid), 32'd0);
    chk("rst.outs", 32'(outs), 32'd0);
    chk("rst.ins_ready", 32'(ins_ready), 32'd1);
    chk("rst.count", 32'(mismatch_count), 32'd0);
    chk("rst.sat", 32'(mismatch_sat), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    //                 v     d      r     ov    outs  ir    cnt
    stream_tbl[0] = '{1'b1, NEG3,  1'b1, 1'b0, 1'b0, 1'b1, 0};
    stream_tbl[1] = '{1'b1, 32'd7, 1'b1, 1'b1, 1'b1, 1'b1, 0};
    stream_tbl[2] = '{1'b1, NEG3,  1'b1, 1'b1, 1'b0, 1'b1, 1};
    stream_tbl[3] = '{1'b1, NEG3,  1'b1, 1'b1, 1'b1, 1'b1, 1};
    stream_tbl[4] = '{1'b1, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1};
    stream_tbl[5] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2};
    stream_tbl[6] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2};

    bp_tbl[0] = '{1'b1, NEG3,  1'b0, 1'b0, 1'b0, 1'b1, 0};
    bp_tbl[1] = '{1'b1, 32'd5, 1'b0, 1'b1, 1'b1, 1'b1, 0};
    bp_tbl[2] = '{1'b1, NEG3,  1'b0, 1'b1, 1'b1, 1'b0, 1};
    bp_tbl[3] = '{1'b1, NEG3,  1'b0, 1'b1, 1'b1, 1'b0, 1};
    bp_tbl[4] = '{1'b1, NEG3,  1'b1, 1'b1, 1'b1, 1'b0, 1};
    bp_tbl[5] = '{1'b1, NEG3,  1'b1, 1'b1, 1'b0, 1'b1, 1};
    bp_tbl[6] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1};
    bp_tbl[7] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1};

    @(negedge clk);
    do_reset();

    // Idle after reset
    for (int i = 0; i < 10; i++) cycle(1'b0, $urandom, 1'b0);

    // Full-rate stream
    for (int i = 0; i < 7; i++) apply_vec(stream_tbl[i], "stream");

    // Backpressure with a stalled third token
    do_reset();
    for (int i = 0; i < 8; i++) apply_vec(bp_tbl[i], "bp");

    // Simultaneous push/pop: outs_ready toggles while input stays valid
    do_reset();
    for (int i = 0; i < 24; i++)
      cycle(1'b1, ($urandom_range(0, 1) != 0) ? NEG3 : $urandom, 1'(i % 2));
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1);

    // Saturation of the narrow counter
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'd100 + 32'(i), 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    chk("sat.count4", 32'(mismatch_count4), 32'd15);
    chk("sat.sat4", 32'(mismatch_sat4), 32'd1);
    chk("sat.count16", 32'(mismatch_count), 32'd20);

    // Reset mid-operation with the buffer full and count=3
    do_reset();
    cycle(1'b1, 32'd1, 1'b1);
    cycle(1'b1, 32'd2, 1'b1);
    cycle(1'b1, 32'd3, 1'b0);
    cycle(1'b1, 32'd4, 1'b0);
    #1;
    chk("mid.full", 32'(ins_ready), 32'd0);
    chk("mid.count", 32'(mismatch_count), 32'd3);
    #1 rst = 1'b0;
    #1;
    chk("mid.rst.outs_valid", 32'(outs_valid), 32'd0);
    chk("mid.rst.outs", 32'(outs), 32'd0);
    chk("mid.rst.count", 32'(mismatch_count), 32'd0);
    chk("mid.rst.ins_ready", 32'(ins_ready), 32'd1);
    q.delete();
    mm_total = 0;
    ins_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, NEG3, 1'b0);
    cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);

    // Randomized traffic against the queue model
    do_reset();
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0) ? $urandom : NEG3,
            1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
